// File: rtl/mpu6050_axis_sequencer_if.sv
// Handshake bundle between the axis sequencer and the single-byte I2C read master.
// master: the sequencer side; slave: the I2C read master side.
interface mpu6050_axis_sequencer_if;
  logic       i2c_start;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_data;
  logic       i2c_data_valid;
  logic       i2c_ready;

  modport master (
    output i2c_start,
    output i2c_reg_addr,
    input  i2c_data,
    input  i2c_data_valid,
    input  i2c_ready
  );

  modport slave (
    input  i2c_start,
    input  i2c_reg_addr,
    output i2c_data,
    output i2c_data_valid,
    output i2c_ready
  );
endinterface

// File: rtl/mpu6050_axis_sequencer.sv
// Scans six MPU6050 data registers through the I2C read master and publishes X/Y/Z atomically.
// Optional per-state watchdog enabled by defining SEQ_TIMEOUT_EN.
//
// state       | meaning
// IDLE        | scanning disabled, waiting for enable
// ISSUE       | start + register address driven, waiting for master idle
// WAIT_BUSY   | start held until the master leaves idle
// WAIT_DATA   | waiting for the rising edge of the data-valid level
// WAIT_DONE   | byte captured, waiting for the master to return to idle
// PUBLISH     | new axes visible with the one-cycle sample_valid strobe
// WAIT_PERIOD | inter-scan delay
module mpu6050_axis_sequencer #(
  parameter logic [7:0]  BASE_REG       = 8'h3B,
  parameter int unsigned PERIOD_CYCLES  = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  mpu6050_axis_sequencer_if.master           bus,
  output logic [15:0]                        axis_x,
  output logic [15:0]                        axis_y,
  output logic [15:0]                        axis_z,
  output logic                               sample_valid,
  output logic                               busy,
  output logic                               error
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY   = 3'd2;
  localparam logic [2:0] S_WAIT_DATA   = 3'd3;
  localparam logic [2:0] S_WAIT_DONE   = 3'd4;
  localparam logic [2:0] S_PUBLISH     = 3'd5;
  localparam logic [2:0] S_WAIT_PERIOD = 3'd6;

  // PUBLISH itself is the first cycle of the period, so the wait state covers PERIOD_CYCLES-1 cycles.
  localparam bit          PERIOD_SHORT = (PERIOD_CYCLES <= 1);
  localparam logic [31:0] PERIOD_LOAD  = PERIOD_SHORT ? 32'd0 : 32'(PERIOD_CYCLES - 2);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  if (PERIOD_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("PERIOD_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]  state, state_nx;
  logic [2:0]  byte_idx;
  logic [7:0]  addr_q;
  logic [47:0] byte_shift;
  logic        prev_valid;
  logic [31:0] period_cnt;
  logic        data_edge;
  logic        timeout_hit;

  assign data_edge        = bus.i2c_data_valid && !prev_valid;
  assign bus.i2c_start    = (state == S_ISSUE) || (state == S_WAIT_BUSY);
  assign bus.i2c_reg_addr = addr_q;
  assign busy             = (state != S_IDLE) && (state != S_WAIT_PERIOD);

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        error_q;
  logic        in_wait;

  assign in_wait     = state inside {S_ISSUE, S_WAIT_BUSY, S_WAIT_DATA, S_WAIT_DONE};
  assign timeout_hit = in_wait && (tcnt == TIMEOUT_LAST);
  assign error       = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (enable) state_nx = S_ISSUE;
      S_ISSUE:       if (bus.i2c_ready) state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY:   if (!bus.i2c_ready) state_nx = S_WAIT_DATA;
      S_WAIT_DATA:   if (data_edge) state_nx = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.i2c_ready) begin
          if (byte_idx == 3'd5) state_nx = S_PUBLISH;
          else if (enable)      state_nx = S_ISSUE;
          else                  state_nx = S_IDLE;
        end
      end
      S_PUBLISH: begin
        if (!PERIOD_SHORT) state_nx = S_WAIT_PERIOD;
        else if (enable)   state_nx = S_ISSUE;
        else               state_nx = S_IDLE;
      end
      S_WAIT_PERIOD: begin
        if (!enable)              state_nx = S_IDLE;
        else if (period_cnt == 0) state_nx = S_ISSUE;
      end
      default:       state_nx = S_IDLE;
    endcase
    if (timeout_hit) state_nx = S_WAIT_PERIOD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_idx     <= '0;
      addr_q       <= '0;
      byte_shift   <= '0;
      prev_valid   <= 1'b0;
      period_cnt   <= '0;
      axis_x       <= '0;
      axis_y       <= '0;
      axis_z       <= '0;
      sample_valid <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tcnt         <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      prev_valid   <= bus.i2c_data_valid;
      sample_valid <= 1'b0;

      if (state_nx == S_ISSUE && state != S_ISSUE) begin
        if (state == S_WAIT_DONE) begin
          byte_idx <= byte_idx + 3'd1;
          addr_q   <= BASE_REG + {5'd0, byte_idx} + 8'd1;
        end else begin
          byte_idx <= '0;
          addr_q   <= BASE_REG;
        end
      end else if (state_nx == S_IDLE) begin
        byte_idx <= '0;
      end

      // A full scan shifts in all six bytes, so stale bytes from an aborted scan never survive.
      if (state == S_WAIT_DATA && state_nx == S_WAIT_DONE)
        byte_shift <= {byte_shift[39:0], bus.i2c_data};

      if (state_nx == S_PUBLISH) begin
        axis_x       <= byte_shift[47:32];
        axis_y       <= byte_shift[31:16];
        axis_z       <= byte_shift[15:0];
        sample_valid <= 1'b1;
      end

      if (state_nx == S_WAIT_PERIOD && state != S_WAIT_PERIOD)
        period_cnt <= PERIOD_LOAD;
      else if (state == S_WAIT_PERIOD && period_cnt != 0)
        period_cnt <= period_cnt - 32'd1;

`ifdef SEQ_TIMEOUT_EN
      if (state_nx != state) tcnt <= '0;
      else if (in_wait)      tcnt <= tcnt + 32'd1;

      if (timeout_hit)               error_q <= 1'b1;
      else if (state_nx == S_PUBLISH) error_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mpu6050_axis_sequencer.sv
// Directed/randomised bench for mpu6050_axis_sequencer with a behavioural I2C read master.
// Timeout scenario runs only when SEQ_TIMEOUT_EN is defined for the build.
module tb_mpu6050_axis_sequencer;
  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 50;
  localparam int BASE    = 'h3B;
  localparam int BUDGET  = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] axis_x, axis_y, axis_z;
  logic        sample_valid, busy, error;

  int          total = 0;
  int          bad = 0;
  int          sv_count = 0;
  bit          stuck = 1'b0;
  logic [7:0]  mem [256];
  logic [7:0]  issued [$];
  logic [47:0] axes_prev = '0;

  mpu6050_axis_sequencer_if bus ();

  mpu6050_axis_sequencer #(
    .BASE_REG      (8'h3B),
    .PERIOD_CYCLES (PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus.master),
    .axis_x      (axis_x),
    .axis_y      (axis_y),
    .axis_z      (axis_z),
    .sample_valid(sample_valid),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] exp_axes();
    return {mem[BASE], mem[BASE+1], mem[BASE+2], mem[BASE+3], mem[BASE+4], mem[BASE+5]};
  endfunction

  task automatic randomize_regs();
    for (int k = 0; k < 6; k++) mem[BASE+k] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_sample(input string tag);
    int n = 0;
    while (sample_valid !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sample_seen"}, 48'(n < BUDGET), 48'd1);
  endtask

  task automatic check_scan(input string tag);
    check({tag, "_nreads"}, 48'(issued.size()), 48'd6);
    for (int k = 0; k < 6 && k < issued.size(); k++)
      check({tag, "_addr"}, 48'(issued[k]), 48'(BASE + k));
    check({tag, "_axes"}, {axis_x, axis_y, axis_z}, exp_axes());
    check({tag, "_err"}, 48'(error), 48'd0);
  endtask

  // Behavioural read master: ready drops 4 cycles after start, valid held 20 cycles,
  // data deliberately changes halfway through the valid pulse.
  initial begin : master_model
    logic [7:0] a;
    bus.i2c_ready      = 1'b1;
    bus.i2c_data_valid = 1'b0;
    bus.i2c_data       = 8'h00;
    forever begin
      @(negedge clk);
      if (!stuck && bus.i2c_start === 1'b1 && bus.i2c_ready === 1'b1) begin
        a = bus.i2c_reg_addr;
        issued.push_back(a);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("start_hold", 48'(bus.i2c_start), 48'd1);
          check("addr_hold", 48'(bus.i2c_reg_addr), 48'(a));
        end
        bus.i2c_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.i2c_data       = mem[a];
        bus.i2c_data_valid = 1'b1;
        repeat (10) @(negedge clk);
        bus.i2c_data = mem[a] ^ 8'hA5;
        repeat (10) @(negedge clk);
        bus.i2c_data_valid = 1'b0;
        bus.i2c_data       = 8'h00;
        repeat (2) @(negedge clk);
        bus.i2c_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (sample_valid === 1'b1) sv_count++;
    if (reset === 1'b0 && {axis_x, axis_y, axis_z} !== axes_prev)
      check("axes_change_with_valid", 48'(sample_valid), 48'd1);
    axes_prev = {axis_x, axis_y, axis_z};
  end

  initial begin : main
    int          n;
    int          svc;
    logic [47:0] saved;

    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_start", 48'(bus.i2c_start), 48'd0);
    check("rst_addr", 48'(bus.i2c_reg_addr), 48'd0);
    check("rst_axes", {axis_x, axis_y, axis_z}, 48'd0);
    check("rst_valid", 48'(sample_valid), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_error", 48'(error), 48'd0);

    // Known-value scan
    mem[BASE+0] = 8'h12; mem[BASE+1] = 8'h34; mem[BASE+2] = 8'hFF;
    mem[BASE+3] = 8'hFE; mem[BASE+4] = 8'h80; mem[BASE+5] = 8'h00;
    reset  = 1'b0;
    enable = 1'b1;
    wait_sample("scan1");
    check("scan1_x", 48'(axis_x), 48'h1234);
    check("scan1_y", 48'(axis_y), 48'hFFFE);
    check("scan1_z", 48'(axis_z), 48'h8000);
    check_scan("scan1");
    randomize_regs();
    issued.delete();
    @(negedge clk);
    check("sv_one_cycle", 48'(sample_valid), 48'd0);

    // Periodic restart: start must rise PERIOD cycles after the strobe
    n = 1;
    while (bus.i2c_start !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("period_gap", 48'(n), 48'(PERIOD));
    wait_sample("scan2");
    check_scan("scan2");
    @(negedge clk);

    // enable dropped during byte 2
    randomize_regs();
    issued.delete();
    saved = {axis_x, axis_y, axis_z};
    svc   = sv_count;
    n = 0;
    while (issued.size() < 3 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_byte2", 48'(n < BUDGET), 48'd1);
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("abort_busy_fall", 48'(n < BUDGET), 48'd1);
    check("abort_byte_done", 48'(bus.i2c_ready), 48'd1);
    check("abort_nreads", 48'(issued.size()), 48'd3);
    check("abort_axes_hold", {axis_x, axis_y, axis_z}, saved);
    repeat (150) @(negedge clk);
    check("abort_no_valid", 48'(sv_count), 48'(svc));
    check("abort_no_restart", 48'(issued.size()), 48'd3);
    check("abort_idle_start", 48'(bus.i2c_start), 48'd0);

    // Reset while waiting for data
    randomize_regs();
    issued.delete();
    enable = 1'b1;
    n = 0;
    while (bus.i2c_ready !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst2_reach_wait", 48'(n < BUDGET), 48'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_start", 48'(bus.i2c_start), 48'd0);
    check("rst2_addr", 48'(bus.i2c_reg_addr), 48'd0);
    check("rst2_axes", {axis_x, axis_y, axis_z}, 48'd0);
    check("rst2_valid", 48'(sample_valid), 48'd0);
    check("rst2_busy", 48'(busy), 48'd0);
    check("rst2_error", 48'(error), 48'd0);
    n = 0;
    while (bus.i2c_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst2_master_idle", 48'(n < BUDGET), 48'd1);
    @(negedge clk);
    issued.delete();
    randomize_regs();
    reset = 1'b0;
    wait_sample("scan3");
    check_scan("scan3");
    @(negedge clk);

`ifdef SEQ_TIMEOUT_EN
    // Master never leaves idle: watchdog aborts the scan
    stuck = 1'b1;
    saved = {axis_x, axis_y, axis_z};
    svc   = sv_count;
    n = 0;
    while (bus.i2c_start !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", 48'(n < BUDGET), 48'd1);
    n = 0;
    while (error !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", 48'(n), 48'(TIMEOUT + 1));
    check("to_start_low", 48'(bus.i2c_start), 48'd0);
    check("to_axes_hold", {axis_x, axis_y, axis_z}, saved);
    check("to_no_valid", 48'(sv_count), 48'(svc));
    stuck = 1'b0;
    issued.delete();
    randomize_regs();
    wait_sample("scan4");
    check_scan("scan4");
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
